// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with programmable almost-full/almost-empty thresholds and sticky error flags
// Ports: clk, rstb (async active-low), sclr (sync clear of pointers/count/flags)
//        wr_en/data_in write side; rd_en/data_out/rd_valid read side
//        empty, full, afull (uw >= afull_lvl), aempty (uw <= aempty_lvl), uw used words
//        stat_clr clears ovf/udf/max_uw; ovf/udf sticky rejected-write/rejected-read flags
// LOOKAHEAD=1 presents the head word on data_out; LOOKAHEAD=0 registers it after an accepted read
// Define SYNC_FIFO_V2_WATERMARK_EN to build the peak-occupancy register behind max_uw
module sync_fifo_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LOOKAHEAD = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  sclr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  input  logic [ADDR_WIDTH:0]   afull_lvl,
  input  logic [ADDR_WIDTH:0]   aempty_lvl,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   uw,
  input  logic                  stat_clr,
  output logic                  ovf,
  output logic                  udf,
  output logic [ADDR_WIDTH:0]   max_uw
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp_q, wp_d, wp_n, rp_q, rp_d, rp_n;
  logic [ADDR_WIDTH:0] uw_q, uw_d, uw_n;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, dout_n, head_n;
  logic rv_q, rv_d, ovf_q, ovf_d, udf_q, udf_d, rd_acc, wr_acc;
  always_comb begin
    empty = uw_q == '0;
    full = uw_q == DEPTH_W;
    afull = uw_q >= afull_lvl;
    aempty = uw_q <= aempty_lvl;
    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
    uw_n = uw_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    wp_n = wp_q + ADDR_WIDTH'(wr_acc);
    rp_n = rp_q + ADDR_WIDTH'(rd_acc);
    // the incoming word becomes the head when the FIFO is otherwise empty after this cycle's read
    head_n = (wr_acc && wp_q == rp_n) ? data_in : mem[rp_n];
    dout_n = (LOOKAHEAD != 0) ? head_n : (rd_acc ? mem[rp_q] : dout_q);
    uw_d = sclr ? '0 : uw_n;
    wp_d = sclr ? '0 : wp_n;
    rp_d = sclr ? '0 : rp_n;
    dout_d = sclr ? '0 : dout_n;
    rv_d = ~sclr & rd_acc;
    ovf_d = ~sclr & ((wr_en & ~wr_acc) | (ovf_q & ~stat_clr));
    udf_d = ~sclr & ((rd_en & ~rd_acc) | (udf_q & ~stat_clr));
    rd_valid = (LOOKAHEAD != 0) ? ~empty : rv_q;
    data_out = dout_q;
    uw = uw_q;
    ovf = ovf_q;
    udf = udf_q;
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      wp_q <= '0;
      rp_q <= '0;
      uw_q <= '0;
      dout_q <= '0;
      rv_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      uw_q <= uw_d;
      dout_q <= dout_d;
      rv_q <= rv_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  always_ff @(posedge clk)
    if (wr_acc && !sclr) mem[wp_q] <= data_in;
`ifdef SYNC_FIFO_V2_WATERMARK_EN
  logic [ADDR_WIDTH:0] max_q, max_d;
  always_comb max_d = (sclr | stat_clr) ? '0 : (uw_n > max_q ? uw_n : max_q);
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) max_q <= '0;
    else max_q <= max_d;
  assign max_uw = max_q;
`else
  assign max_uw = '0;
`endif
endmodule
